// File: rtl/test_reporter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : test_reporter_pkg                                              |
// | Purpose : Shared types and constants for the test result reporter:       |
// |           report FSM states, register word offsets, STATUS bit fields    |
// |           and a small helper for sizing the phase counter.               |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package test_reporter_pkg;

  // Report sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Register select, taken from wb_adr_i[3:2]
  localparam logic [1:0] c_reg_result = 2'd0;  // 0x0
  localparam logic [1:0] c_reg_status = 2'd1;  // 0x4
  localparam logic [1:0] c_reg_config = 2'd2;  // 0x8

  // STATUS field positions
  localparam int c_stat_level_msb = 4;
  localparam int c_stat_busy      = 5;
  localparam int c_stat_fail      = 6;
  localparam int c_stat_ovf       = 7;
  localparam int c_stat_clr_cnt   = 8;
  localparam int c_stat_cnt_lsb   = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : result_fifo                                                    |
// | Purpose : 1-bit wide synchronous FIFO holding queued test results.       |
// |           Simultaneous push/pop are both honoured, even when full.       |
// |           Flush empties the FIFO and takes priority over push/pop.       |
// | Ports   : clk, rst_n        clock, async active-low reset                |
// |           i_push, i_din     write strobe and result bit                  |
// |           i_pop             read strobe (ignored when empty)             |
// |           i_flush           discard all entries                          |
// |           o_dout            head entry (valid when !o_empty)             |
// |           o_empty, o_full   occupancy flags                              |
// |           o_level           number of stored entries                     |
// |           o_overflow        push dropped this cycle (full, no pop)       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_din,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_dout,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_pop_ok;
  logic w_push_ok;

  always_comb begin
    o_empty    = (r_level == '0);
    o_full     = (r_level == LVL_W'(DEPTH));
    w_pop_ok   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted. When full, wr_ptr == rd_ptr: the head is read
    // combinationally before the edge that overwrites that slot.
    w_push_ok  = i_push & (~o_full | w_pop_ok);
    o_overflow = i_push & o_full & ~w_pop_ok & ~i_flush;
    o_dout     = r_mem[r_rd_ptr];
    o_level    = r_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_result_reporter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : test_result_reporter                                           |
// | Purpose : Wishbone slave through which firmware reports per-test         |
// |           pass/fail. Results are queued in a small FIFO and serialised   |
// |           onto io_success (level) / io_next_test (strobe) with fixed     |
// |           setup, pulse and gap timing.                                   |
// | Ports   : wb_clk_i, wb_rst_n_i   clock, async active-low reset           |
// |           wb_cyc_i/stb_i/we_i    Wishbone classic handshake              |
// |           wb_sel_i, wb_adr_i     byte selects, byte offset ([3:2] used)  |
// |           wb_dat_i/dat_o, ack_o  data in/out, acknowledge                |
// |           io_success             reported result level (1 = pass)       |
// |           io_next_test           report strobe                          |
// |           io_oeb                 active-low enables {next_test,success} |
// | Registers: 0x0 RESULT(W) 0x4 STATUS(R/W1C) 0x8 CONFIG(RW)                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module test_result_reporter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int PULSE_CYCLES = 16,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        io_success,
  output logic        io_next_test,
  output logic [1:0]  io_oeb
);

  import test_reporter_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES) + 1);

  localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);

  // Registers
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_enable;
  logic             r_fail;
  logic             r_ovf;
  logic [15:0]      r_count;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_success;
  logic             r_next_test;

  // Bus decode
  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_reg;
  logic        w_push;
  logic        w_cfg_wr;
  logic        w_clr_fail;
  logic        w_clr_ovf;
  logic        w_clr_cnt;
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  // FIFO interface
  logic             w_head;
  logic             w_empty;
  logic             w_full;
  logic [LVL_W-1:0] w_level;
  logic             w_fifo_ovf;

  // FSM next-state / controls
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_success_nxt;
  logic             w_next_test_nxt;
  logic             w_pop;
  logic             w_flush;
  logic             w_report_done;
  logic             w_start;

  logic w_unused;
  assign w_unused = ^{wb_dat_i[31:9], wb_dat_i[5:1], wb_sel_i[3:2],
                      wb_adr_i[1:0], w_full};

  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;
  assign io_success   = r_success;
  assign io_next_test = r_next_test;
  assign io_oeb       = {2{~r_enable}};

  // ------------------------------------------------------------------
  // Wishbone decode
  // ------------------------------------------------------------------
  always_comb begin
    // Gating with r_ack makes each access exactly one ack long and
    // prevents a held cyc/stb from producing back-to-back acks.
    w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
    w_wr       = w_req & wb_we_i;
    w_rd       = w_req & ~wb_we_i;
    w_reg      = wb_adr_i[3:2];
    w_push     = w_wr & (w_reg == c_reg_result) & wb_sel_i[0];
    w_cfg_wr   = w_wr & (w_reg == c_reg_config) & wb_sel_i[0];
    w_clr_fail = w_wr & (w_reg == c_reg_status) & wb_sel_i[0] & wb_dat_i[c_stat_fail];
    w_clr_ovf  = w_wr & (w_reg == c_reg_status) & wb_sel_i[0] & wb_dat_i[c_stat_ovf];
    w_clr_cnt  = w_wr & (w_reg == c_reg_status) & wb_sel_i[1] & wb_dat_i[c_stat_clr_cnt];

    w_status                                     = '0;
    w_status[c_stat_level_msb:0]                 = 5'(w_level);
    w_status[c_stat_busy]                        = (r_state != ST_IDLE);
    w_status[c_stat_fail]                        = r_fail;
    w_status[c_stat_ovf]                         = r_ovf;
    w_status[c_stat_cnt_lsb+15:c_stat_cnt_lsb]   = r_count;

    case (w_reg)
      c_reg_status: w_rdata = w_status;
      c_reg_config: w_rdata = {31'd0, r_enable};
      default:      w_rdata = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Result FIFO
  // ------------------------------------------------------------------
  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .i_push     (w_push),
    .i_din      (wb_dat_i[0]),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_dout     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_level    (w_level),
    .o_overflow (w_fifo_ovf)
  );

  // ------------------------------------------------------------------
  // Report sequencer: next state
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_success_nxt   = r_success;
    w_next_test_nxt = r_next_test;
    w_pop           = 1'b0;
    w_flush         = 1'b0;
    w_report_done   = 1'b0;
    w_start         = r_enable & ~w_empty;

    if (!r_enable && (r_state != ST_IDLE)) begin
      // Disabled mid-report: abandon the report and drop the queue.
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_next_test_nxt = 1'b0;
      w_flush         = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_pop         = 1'b1;
            w_success_nxt = w_head;
            w_state_nxt   = ST_SETUP;
            w_cnt_nxt     = '0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == c_setup_last) begin
            w_next_test_nxt = 1'b1;
            w_state_nxt     = ST_PULSE;
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (r_cnt == c_pulse_last) begin
            w_next_test_nxt = 1'b0;
            w_report_done   = 1'b1;
            w_state_nxt     = ST_GAP;
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == c_gap_last) begin
            // Chain straight into the next report when one is waiting so
            // that strobe period is exactly SETUP+PULSE+GAP cycles, with
            // no extra idle cycle in between.
            w_cnt_nxt = '0;
            if (w_start) begin
              w_pop         = 1'b1;
              w_success_nxt = w_head;
              w_state_nxt   = ST_SETUP;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Report sequencer: state register
  // ------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_success   <= 1'b0;
      r_next_test <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_success   <= w_success_nxt;
      r_next_test <= w_next_test_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Bus response, configuration and status bookkeeping
  // ------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_enable <= 1'b0;
      r_fail   <= 1'b0;
      r_ovf    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;

      if (w_cfg_wr) begin
        r_enable <= wb_dat_i[0];
      end

      // A new event in the same cycle as a W1C keeps the sticky bit set.
      if (w_report_done && !r_success) begin
        r_fail <= 1'b1;
      end else if (w_clr_fail) begin
        r_fail <= 1'b0;
      end

      if (w_fifo_ovf) begin
        r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
        r_ovf <= 1'b0;
      end

      if (w_clr_cnt) begin
        r_count <= '0;
      end else if (w_report_done && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
